alu_req_ctrl: RTL and testbench

- Requester-side sequencer for the unified ALU (add, sub, mul, div, fp-add; 6-bit select, 32-bit operands and result).
- Accepts one operation request per transaction on a valid/ready front end.
- Drives the ALU operand and select inputs and holds them stable for a fixed window, so the ALU's free-running 32-cycle sampling period is always covered.
- Captures the ALU result and returns it on a valid/ready response channel.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_hold_counter.sv | 24 ++
 rtl/alu_req_ctrl.sv | 111 +++++++++++
 tb/tb_alu_req_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, ALU timing constant and controller state encoding
// shared by alu_req_ctrl and its sub-modules.
package alu_pkg;
    localparam int OP_ADD            = 0;
    localparam int OP_SUB            = 1;
    localparam int OP_MUL            = 2;
    localparam int OP_DIV            = 3;
    localparam int OP_FADD           = 4;
    localparam int OP_MAX            = 4;
    localparam int ALU_SAMPLE_PERIOD = 32;

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_e;
endpackage

// File: rtl/alu_hold_counter.sv
// alu_hold_counter: clearable up-counter that raises tc at HOLD_CYCLES-1 and
// then stays there until cleared, so it never wraps inside a hold window.
module alu_hold_counter #(
    parameter int HOLD_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(HOLD_CYCLES) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = cnt_q == CW'(HOLD_CYCLES - 1);

    always_comb cnt_d = clr ? '0 : (en && !tc) ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/alu_req_ctrl.sv
// alu_req_ctrl: requester-side sequencer for the unified ALU; holds operands for
// HOLD_CYCLES before capturing the result. Optional macro: ALU_CTRL_DIV0_CHECK_EN.
module alu_req_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int OP_W        = 6,
    parameter int HOLD_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_sr,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
    logic [OP_W-1:0]  alu_sr_q, alu_sr_d;
    logic             rsp_err_q, rsp_err_d;
    logic             accept, op_bad, div0, reject, tc;

    assign accept = req_valid && state_q == IDLE;
    assign op_bad = req_op > OP_W'(OP_MAX);
`ifdef ALU_CTRL_DIV0_CHECK_EN
    assign div0   = req_op == OP_W'(OP_DIV) && req_b == '0;
`else
    assign div0   = 1'b0;
`endif
    assign reject = op_bad || div0;

    alu_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_q == HOLD),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sr_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sr_q   <= alu_sr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (reject ? RESP : HOLD) : IDLE;
            HOLD:    state_d = tc ? RESP : HOLD;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Rejected requests leave alu_* untouched so the ALU output stays stable.
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sr_d   = alu_sr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (accept && !reject) begin
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            alu_sr_d = req_op;
        end
        if (accept && reject) begin
            rsp_data_d = op_bad ? '0 : '1;
            rsp_err_d  = 1'b1;
        end
        if (state_q == HOLD && tc) begin
            rsp_data_d = alu_y;
            rsp_err_d  = 1'b0;
        end
    end

    always_comb begin
        req_ready = state_q == IDLE;
        rsp_valid = state_q == RESP;
        busy      = state_q != IDLE;
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sr   = alu_sr_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_alu_req_ctrl.sv
// tb_alu_req_ctrl: table-driven bench for alu_req_ctrl with a sampling ALU model
// and a response scoreboard; honours ALU_CTRL_DIV0_CHECK_EN.
module tb_alu_req_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [5:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [31:0] alu_a, alu_b, alu_y = '0;
    logic [5:0]  alu_sr;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [31:0] rsp_data;

    int total = 0, bad = 0, cyc = 0;
    logic [31:0] last_a = '0, last_b = '0;
    logic [5:0]  last_op = '0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, data;
        logic        err;
        int          lat, bp;
        bit          junk, overlap;
    } vec_t;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vt[8];
    exp_t sb[$];

    alu_req_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sr(alu_sr), .alu_y(alu_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, b, input logic [5:0] s);
        case (s)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a * b;
            6'd3:    return (b == 0) ? 32'hDEAD_BEEF : a / b;
            6'd4:    return a + b;
            default: return 32'h0;
        endcase
    endfunction

    // The ALU only samples its inputs once every 32 cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc % 32 == 0) alu_y <= alu_model(alu_a, alu_b, alu_sr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        int   lat;
        bit   ok, stable;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
        sb.push_back('{v.data, v.err, v.lat});
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        ok = 1'b1;
        while (!rsp_valid && lat < 200) begin
            if (req_ready || !busy || alu_sr !== v.op || alu_a !== v.a || alu_b !== v.b) ok = 1'b0;
            if (v.junk) begin
                req_valid = lat[0]; req_op = 6'd1; req_a = 32'd99; req_b = 32'd1;
            end
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        e = sb.pop_front();
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("latency", lat, e.lat);
        if (v.err) begin
            check("alu_ab_untouched", {alu_a, alu_b}, {last_a, last_b});
            check("alu_sr_untouched", alu_sr, last_op);
        end else begin
            check("hold_stable", ok, 1);
            last_a = v.a; last_b = v.b; last_op = v.op;
        end
        stable = 1'b1;
        repeat (v.bp) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== e.data || rsp_err !== e.err || req_ready) stable = 1'b0;
        end
        if (v.bp > 0) check("backpressure_stable", stable, 1);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", rsp_err, e.err);
        rsp_ready = 1'b1;
        if (v.overlap) begin
            req_valid = 1'b1; req_op = 6'd0; req_a = 32'd1; req_b = 32'd2;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("req_ready_after", req_ready, 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int  seen;
        vec_t v;
        vt[0] = '{6'd0, 32'd5,   32'd7,  32'd12, 1'b0, 65, 0,  1'b0, 1'b0};
        vt[1] = '{6'd1, 32'd10,  32'd3,  32'd7,  1'b0, 65, 0,  1'b0, 1'b0};
        vt[2] = '{6'd2, 32'd6,   32'd7,  32'd42, 1'b0, 65, 0,  1'b1, 1'b0};
        vt[3] = '{6'd9, 32'd55,  32'd66, 32'd0,  1'b1, 1,  0,  1'b0, 1'b0};
        vt[4] = '{6'd0, 32'd20,  32'd22, 32'd42, 1'b0, 65, 10, 1'b0, 1'b1};
`ifdef ALU_CTRL_DIV0_CHECK_EN
        vt[5] = '{6'd3, 32'd100, 32'd0,  32'hFFFF_FFFF, 1'b1, 1,  0, 1'b0, 1'b0};
`else
        vt[5] = '{6'd3, 32'd100, 32'd0,  32'hDEAD_BEEF, 1'b0, 65, 0, 1'b0, 1'b0};
`endif
        vt[6] = '{6'd3, 32'd100, 32'd7,  32'd14, 1'b0, 65, 0,  1'b0, 1'b0};
        vt[7] = '{6'd4, 32'd3,   32'd4,  32'd7,  1'b0, 65, 0,  1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {req_ready, rsp_valid, rsp_err, busy}, 4'b1000);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_alu", {alu_a, alu_b, alu_sr}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vt[i]);

        // Abort a multiply 30 cycles into HOLD.
        @(negedge clk);
        req_valid = 1'b1; req_op = 6'd2; req_a = 32'd6; req_b = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        check("in_hold_before_abort", {busy, req_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("abort_flags", {req_ready, rsp_valid, rsp_err, busy}, 4'b1000);
        check("abort_rsp_data", rsp_data, 0);
        check("abort_alu", {alu_a, alu_b, alu_sr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_a = '0; last_b = '0; last_op = '0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        check("no_rsp_after_abort", seen, 0);

        v = '{6'd0, 32'd1, 32'd1, 32'd2, 1'b0, 65, 0, 1'b0, 1'b0};
        run_txn(v);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
